// File: rtl/req_encoder_7.sv
// Sticky 7-line request collector presenting one registered index + one-hot per valid/ready transfer.
// Build option REQ_ENC_ROUND_ROBIN_EN: round-robin priority; default build uses fixed lowest-index priority.
module req_encoder_7 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] req_i,
  input  logic [6:0] mask_i,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] out_idx,
  output logic [6:0] out_onehot,
  output logic [6:0] pending,
  output logic       overflow
);
  localparam int N_REQ = 7;
  localparam int IDX_W = 3;
  localparam logic [IDX_W:0] LP_NREQ = 4'd7;

  typedef enum logic {S_IDLE, S_PRESENT} state_t;

  state_t           r_state;
  logic [N_REQ-1:0] r_pending;
  logic [N_REQ-1:0] r_onehot;
  logic [IDX_W-1:0] r_idx;
  logic             r_valid;
  logic             r_overflow;

  logic             w_hs;
  logic [N_REQ-1:0] w_clr;
  logic [N_REQ-1:0] w_elig;
  logic [N_REQ-1:0] w_sel_oh;
  logic [IDX_W-1:0] w_start;
  logic [IDX_W-1:0] w_sel_idx;
  logic             w_sel_found;

`ifdef REQ_ENC_ROUND_ROBIN_EN
  logic [IDX_W-1:0] r_rr_ptr;
  assign w_start = r_rr_ptr;
`else
  assign w_start = '0;
`endif

  // Walks start, start+1, ... (mod 7); iterating backwards lets the first hit in search order win.
  function automatic logic [IDX_W:0] f_pick(input logic [N_REQ-1:0] elig,
                                            input logic [IDX_W-1:0] start);
    logic [IDX_W:0] res;
    logic [IDX_W:0] k;
    res = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      k = {1'b0, start} + i[IDX_W:0];
      if (k >= LP_NREQ) k = k - LP_NREQ;
      if (elig[k[IDX_W-1:0]]) res = {1'b1, k[IDX_W-1:0]};
    end
    return res;
  endfunction

  assign w_hs   = r_valid & out_ready;
  assign w_clr  = w_hs ? r_onehot : '0;
  assign w_elig = r_pending & mask_i;
  assign {w_sel_found, w_sel_idx} = f_pick(w_elig, w_start);
  assign w_sel_oh = {{(N_REQ-1){1'b0}}, 1'b1} << w_sel_idx;

  // A request arriving on the same edge its bit is accepted survives as a fresh request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending  <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | req_i;
      if (|(req_i & r_pending & ~w_clr)) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_valid  <= 1'b0;
      r_idx    <= '0;
      r_onehot <= '0;
`ifdef REQ_ENC_ROUND_ROBIN_EN
      r_rr_ptr <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_sel_found) begin
            r_idx    <= w_sel_idx;
            r_onehot <= w_sel_oh;
            r_valid  <= 1'b1;
            r_state  <= S_PRESENT;
          end
        end
        S_PRESENT: begin
          if (w_hs) begin
            r_valid  <= 1'b0;
            r_onehot <= '0;
            r_state  <= S_IDLE;
`ifdef REQ_ENC_ROUND_ROBIN_EN
            r_rr_ptr <= (r_idx == 3'd6) ? 3'd0 : r_idx + 3'd1;
`endif
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_valid  = r_valid;
  assign out_idx    = r_idx;
  assign out_onehot = r_onehot;
  assign pending    = r_pending;
  assign overflow   = r_overflow;
endmodule

// File: tb/tb_req_encoder_7.sv
// Directed self-checking bench for req_encoder_7; expectations follow the REQ_ENC_ROUND_ROBIN_EN build choice.
module tb_req_encoder_7;
  logic       clk;
  logic       rst_n;
  logic [6:0] req_i;
  logic [6:0] mask_i;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_idx;
  logic [6:0] out_onehot;
  logic [6:0] pending;
  logic       overflow;

  int n_checks = 0;
  int n_errors = 0;

  req_encoder_7 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_i      (req_i),
    .mask_i     (mask_i),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_idx    (out_idx),
    .out_onehot (out_onehot),
    .pending    (pending),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  int gi[$];
  int gc[$];

  initial begin
    rst_n = 1'b0; req_i = '0; mask_i = 7'h7F; out_ready = 1'b0;
    #2;
    check_eq("rst_valid",   out_valid,  0);
    check_eq("rst_idx",     out_idx,    0);
    check_eq("rst_onehot",  out_onehot, 0);
    check_eq("rst_pending", pending,    0);
    check_eq("rst_ovf",     overflow,   0);
    tick(); tick();
    rst_n = 1'b1;

    // Single request, two-edge latency.
    out_ready = 1'b1; req_i = 7'b0000100;
    tick(); req_i = '0;
    check_eq("single_pend", pending, 7'h04);
    check_eq("single_v0",   out_valid, 0);
    tick();
    check_eq("single_v1",   out_valid, 1);
    check_eq("single_idx",  out_idx, 2);
    check_eq("single_oh",   out_onehot, 7'b0000100);
    tick();
    check_eq("single_vdone", out_valid, 0);
    check_eq("single_ohz",   out_onehot, 0);
    check_eq("single_pclr",  pending, 0);
    check_eq("single_ovf",   overflow, 0);
    check_eq("single_hold",  out_idx, 2);

    // All seven lines at once: grants 0..6 every second cycle.
    tick(); do_reset();
    out_ready = 1'b1; req_i = 7'h7F;
    tick(); req_i = '0;
    for (int c = 2; c <= 20; c++) begin
      tick();
      if (out_valid) begin
        gi.push_back(int'(out_idx));
        gc.push_back(c);
      end
    end
    check_eq("all_count", gi.size(), 7);
    for (int i = 0; i < gi.size() && i < 7; i++) check_eq("all_order", gi[i], i);
    for (int i = 1; i < gc.size(); i++) check_eq("all_gap", gc[i] - gc[i-1], 2);
    check_eq("all_idle", out_valid, 0);
    check_eq("all_pend", pending, 0);
    check_eq("all_ovf",  overflow, 0);

    // Pending {1,5}; line 1 re-requested in the cycle it is accepted.
    do_reset();
    out_ready = 1'b1; req_i = 7'b0100010;
    tick(); req_i = '0;
    tick();
    check_eq("prio_g0", {out_valid, out_idx}, {1'b1, 3'd1});
    req_i = 7'b0000010;
    tick(); req_i = '0;
    check_eq("prio_reset_pend", pending, 7'h22);
    check_eq("prio_ovf", overflow, 0);
    tick();
`ifdef REQ_ENC_ROUND_ROBIN_EN
    check_eq("prio_g1", {out_valid, out_idx}, {1'b1, 3'd5});
`else
    check_eq("prio_g1", {out_valid, out_idx}, {1'b1, 3'd1});
`endif
    tick(); tick();
`ifdef REQ_ENC_ROUND_ROBIN_EN
    check_eq("prio_g2", {out_valid, out_idx}, {1'b1, 3'd1});
`else
    check_eq("prio_g2", {out_valid, out_idx}, {1'b1, 3'd5});
`endif
    tick();
    check_eq("prio_empty", pending, 0);

    // Backpressure with index 3 presented; mask toggling and a new request on line 0.
    do_reset();
    out_ready = 1'b0; req_i = 7'b0011000;
    tick(); req_i = '0;
    tick();
    for (int c = 0; c < 10; c++) begin
      mask_i = (c % 2 == 0) ? 7'h00 : 7'h7F;
      req_i  = (c == 2) ? 7'b0000001 : 7'b0000000;
      tick();
      check_eq("bp_hold", {out_valid, out_idx, out_onehot}, {1'b1, 3'd3, 7'b0001000});
    end
    req_i = '0; mask_i = 7'h7F; out_ready = 1'b1;
    tick();
    check_eq("bp_acc", out_valid, 0);
    check_eq("bp_pend", pending, 7'h11);
    tick();
`ifdef REQ_ENC_ROUND_ROBIN_EN
    check_eq("bp_next", {out_valid, out_idx}, {1'b1, 3'd4});
`else
    check_eq("bp_next", {out_valid, out_idx}, {1'b1, 3'd0});
`endif
    check_eq("bp_ovf", overflow, 0);

    // Fully masked pending bit waits until unmasked.
    do_reset();
    out_ready = 1'b1; mask_i = 7'h00; req_i = 7'b0000100;
    tick(); req_i = '0;
    tick(); tick();
    check_eq("mask_wait_v", out_valid, 0);
    check_eq("mask_wait_p", pending, 7'h04);
    mask_i = 7'h7F;
    tick();
    check_eq("mask_release", {out_valid, out_idx}, {1'b1, 3'd2});
    mask_i = 7'h7F;

    // Same-cycle re-set of line 6, then overflow on repeated requests while held.
    do_reset();
    out_ready = 1'b1; req_i = 7'b1000000;
    tick(); req_i = '0;
    tick();
    check_eq("ov_pres6", {out_valid, out_idx}, {1'b1, 3'd6});
    req_i = 7'b1000000;
    tick(); req_i = '0; out_ready = 1'b0;
    check_eq("reset6_pend", pending, 7'h40);
    check_eq("reset6_ovf",  overflow, 0);
    tick();
    check_eq("ov_pres6b", {out_valid, out_idx}, {1'b1, 3'd6});
    req_i = 7'b1000000;
    tick(); req_i = '0;
    check_eq("ov_set", overflow, 1);
    tick();
    req_i = 7'b1000000;
    tick(); req_i = '0;
    tick(); tick();
    check_eq("ov_sticky", overflow, 1);
    check_eq("ov_pend",   pending, 7'h40);

    // Asynchronous reset while a grant is presented.
    check_eq("mid_pre_valid", out_valid, 1);
    rst_n = 1'b0;
    #2;
    check_eq("mid_valid",  out_valid, 0);
    check_eq("mid_idx",    out_idx, 0);
    check_eq("mid_onehot", out_onehot, 0);
    check_eq("mid_pend",   pending, 0);
    check_eq("mid_ovf",    overflow, 0);
    rst_n = 1'b1;
    tick();
    check_eq("mid_after", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/req_encoder_7.md
Name: req_encoder_7

Overview:
- Encoder counterpart to the 3-bit-to-one-hot select decoder. Collects up to 7 request lines into sticky pending bits.
- Picks one pending, unmasked request and presents it as a registered 3-bit index plus a matching one-hot vector, using a valid/ready handshake.
- Sits between peripheral/event sources and the soft-processor control path, which consumes one index per accepted transfer.

Parameters:
- N_REQ, 7, number of request lines. Fixed at 7 and must not be overridden.
- IDX_W, 3, index width. Fixed at 3.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_i  input  7  request pulses or levels, sampled every rising edge.
- mask_i  input  7  1 = request line eligible for selection; pending is still recorded when 0.
- out_valid  output  1  out_idx/out_onehot hold a selected request.
- out_ready  input  1  consumer accepts when out_valid && out_ready at a rising edge.
- out_idx  output  3  selected request index, 0..6.
- out_onehot  output  7  one-hot of out_idx; all zeros when out_valid=0.
- pending  output  7  current pending register.
- overflow  output  1  sticky flag: a request was lost.

Behaviour:
- Reset (async, rst_n=0):
  - pending=0, out_valid=0, out_idx=0, out_onehot=0, overflow=0.
  - Round-robin pointer rr_ptr=0.
  - State=IDLE.
- Pending update each edge: pending <= (pending & ~clr) | req_i.
  - clr = out_onehot when a handshake occurs that cycle, else 0.
  - A req_i bit asserted in the same cycle its pending bit is cleared by accept re-sets that bit; the new request is kept.
- Overflow: set at an edge when req_i[k]=1, pending[k]=1 and clr[k]=0. Stays set until reset.
- Eligible vector: elig = pending & mask_i.
- State machine, 2 states:
  - IDLE:
    - If elig != 0: select index s by priority, register out_idx=s, out_onehot=1<<s, out_valid=1, go to PRESENT.
    - Else stay in IDLE with out_valid=0.
  - PRESENT:
    - out_idx, out_onehot and out_valid are held stable until the handshake, regardless of mask_i or req_i changes.
    - On handshake: clear pending[out_idx], set rr_ptr=(out_idx==6)?0:out_idx+1, out_valid=0, out_onehot=0, go to IDLE.
    - out_idx keeps its last value while out_valid=0.
- Priority (round-robin): the first eligible index found searching rr_ptr, rr_ptr+1, ... with wrap 6->0.
- Latency:
  - req_i high in cycle 0 -> pending bit set at edge 1 -> out_valid high after edge 2.
  - Throughput: at most one grant per 2 cycles, because of the IDLE bubble.
- Index 7 is never produced. out_onehot always has exactly one bit set while out_valid=1.
- out_ready while out_valid=0: ignored, with no side effects.
- All-masked pending bits: remain pending with no output until unmasked.
- Async reset mid-transfer: all state is cleared immediately, and any presented request is dropped.

Optional Feature:
- Macro REQ_ENC_ROUND_ROBIN_EN.
- Defined: the round-robin priority described above, with rr_ptr updated on each handshake.
- Undefined: fixed priority, where the lowest eligible index wins. rr_ptr is not implemented and the selection search always starts at 0.
- All other behaviour is identical with or without the macro.

Test Plan:
- Reset then single request: pulse req_i=7'b0000100 for one cycle, mask_i=7'h7F, out_ready=1.
  - Required: out_valid=1 two edges later with out_idx=2, out_onehot=7'b0000100.
  - Required: pending returns to 0 after the accept, overflow=0.
- Round-robin (macro defined): req_i=7'h7F held for one cycle, out_ready=1.
  - Required grant order 0,1,2,3,4,5,6, one grant every 2 cycles, then out_valid stays 0.
- Fixed priority (macro undefined): pending {1,5}, then req_i[1] pulsed again after the first accept.
  - Required grants: 1, 1, 5.
- Backpressure: out_ready=0 for 10 cycles with out_idx=3 presented; toggle mask_i and pulse req_i[0] during that time.
  - Required: out_idx=3 and out_valid stay stable.
  - Required: after out_ready=1, the next grant is 4 (rr) or 0 (fixed).
- Overflow and re-set:
  - Pulse req_i[6] twice while pending[6]=1 and not being accepted -> overflow=1, sticky.
  - Assert req_i[6] in the same cycle as the index-6 accept -> pending[6]=1 after that edge.
- Reset mid-operation: drop rst_n while out_valid=1.
  - Required: all outputs 0 immediately, with no clk edge needed.
